// File: rtl/fir_mem_engine.sv
// fir_mem_engine: fabric-side FIR engine on the fir_memory s2 port.
// Loads T coefficients into local registers. For each output n it reads the
// needed samples newest-first and accumulates h[k]*x[n-k], then writes y[n]
// back to memory. A done pulse follows the last write.
module fir_mem_engine #(
    parameter int MAX_TAPS = 32,
    parameter int RD_LAT   = 1,
    parameter int ACC_W    = 40
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        start,
    input  logic [13:0] coef_base,
    input  logic [13:0] src_base,
    input  logic [13:0] dst_base,
    input  logic [5:0]  num_taps,
    input  logic [13:0] num_samples,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [13:0] s2_address,
    output logic        s2_chipselect,
    output logic        s2_clken,
    output logic        s2_write,
    output logic [63:0] s2_writedata,
    output logic [7:0]  s2_byteenable,
    input  logic [63:0] s2_readdata
);

    localparam int         IDX_W = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1;
    localparam logic [6:0] MAX_T = 7'(MAX_TAPS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_MAC    = 3'd2,
        S_WRITE  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    // s2 bus protocol: s2 is a fixed-latency slave with no wait request.
    // A cycle with chipselect=1/write=0 is a read whose data is on s2_readdata
    // exactly RD_LAT cycles later; chipselect=1/write=1 commits writedata in
    // that same cycle. chipselect is 0 in every cycle without an access.

    state_t                  r_state;
    state_t                  w_state_nxt;

    // Job parameters, frozen at accept
    logic [13:0]             r_coef_base;
    logic [13:0]             r_src_base;
    logic [13:0]             r_dst_base;
    logic [13:0]             r_n_total;
    logic [5:0]              r_taps;

    // Sequencing counters
    logic [13:0]             r_n;
    logic [5:0]              r_iss_cnt;
    logic [5:0]              r_ret_cnt;
    logic [RD_LAT-1:0]       r_rd_pipe;

    // Datapath
    logic signed [ACC_W-1:0] r_acc;
    logic signed [15:0]      r_coef [MAX_TAPS];

    // Registered outputs
    logic                    r_busy;
    logic                    r_done;
    logic                    r_error;
    logic                    r_cs;
    logic                    r_wr;
    logic [13:0]             r_addr;
    logic [63:0]             r_wdata;

    // Combinational next values
    logic                    w_accept;
    logic                    w_bad_taps;
    logic                    w_go_run;
    logic                    w_issued;
    logic                    w_ret;
    logic [14:0]             w_n_p1;
    logic [5:0]              w_kn;
    logic                    w_last_coef;
    logic                    w_last_mac;
    logic                    w_last_n;
    logic signed [15:0]      w_h;
    logic signed [15:0]      w_x;
    logic signed [31:0]      w_prod;
    logic signed [ACC_W-1:0] w_acc_nxt;
    logic                    w_cs_nxt;
    logic                    w_wr_nxt;
    logic [13:0]             w_addr_nxt;
    logic [63:0]             w_wdata_nxt;
    logic [5:0]              w_iss_nxt;
    logic [5:0]              w_ret_nxt;
    logic [13:0]             w_n_nxt;
    logic                    w_acc_clr;
    logic                    w_done_nxt;
    logic                    w_err_nxt;
    logic                    w_busy_nxt;
    logic                    w_unused;

    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_bad_taps  = (num_taps == 6'd0) || ({1'b0, num_taps} > MAX_T);
    assign w_go_run    = w_accept && !w_bad_taps && (num_samples != 14'd0);

    // A read leaves the pipe RD_LAT cycles after issue; returns are in order
    assign w_issued    = r_cs && !r_wr;
    assign w_ret       = r_rd_pipe[RD_LAT-1];

    // Kn = min(n+1, T): number of taps that touch non-negative sample indices
    assign w_n_p1      = {1'b0, r_n} + 15'd1;
    assign w_kn        = (w_n_p1 >= {9'd0, r_taps}) ? r_taps : w_n_p1[5:0];

    assign w_last_coef = w_ret && (r_ret_cnt == r_taps - 6'd1);
    assign w_last_mac  = w_ret && (r_ret_cnt == w_kn - 6'd1);
    assign w_last_n    = ((r_n + 14'd1) == r_n_total);

    // Return k of output n pairs with h[k], since samples are read newest-first
    assign w_h         = r_coef[r_ret_cnt[IDX_W-1:0]];
    assign w_x         = s2_readdata[15:0];
    assign w_prod      = 32'(w_h) * 32'(w_x);
    assign w_acc_nxt   = w_ret ? (r_acc + ACC_W'(w_prod)) : r_acc;

    assign w_unused    = ^s2_readdata[63:16];

    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign s2_address    = r_addr;
    assign s2_chipselect = r_cs;
    assign s2_clken      = r_busy;
    assign s2_write      = r_wr;
    assign s2_writedata  = r_wdata;
    assign s2_byteenable = 8'hFF;

    // State register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decision
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_go_run) w_state_nxt = S_LOAD;
            S_LOAD:   if (w_last_coef) w_state_nxt = S_MAC;
            S_MAC:    if (w_last_mac) w_state_nxt = S_WRITE;
            S_WRITE:  w_state_nxt = w_last_n ? S_FINISH : S_MAC;
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of bus strobes, status flags and counters; the first access
    // of each phase is set up on the edge that enters it so it starts at once
    always_comb begin
        w_cs_nxt    = 1'b0;
        w_wr_nxt    = 1'b0;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_iss_nxt   = r_iss_cnt;
        w_ret_nxt   = w_ret ? (r_ret_cnt + 6'd1) : r_ret_cnt;
        w_n_nxt     = r_n;
        w_acc_clr   = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_error;
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_err_nxt  = w_bad_taps;
                    w_done_nxt = !w_go_run;
                end
                if (w_go_run) begin
                    w_cs_nxt   = 1'b1;
                    w_addr_nxt = coef_base;
                    w_iss_nxt  = 6'd1;
                    w_ret_nxt  = 6'd0;
                    w_n_nxt    = 14'd0;
                end
            end
            S_LOAD: begin
                if (w_last_coef) begin
                    w_cs_nxt   = 1'b1;
                    w_addr_nxt = r_src_base;
                    w_iss_nxt  = 6'd1;
                    w_ret_nxt  = 6'd0;
                    w_acc_clr  = 1'b1;
                end else if (r_iss_cnt < r_taps) begin
                    w_cs_nxt   = 1'b1;
                    w_addr_nxt = r_coef_base + 14'(r_iss_cnt);
                    w_iss_nxt  = r_iss_cnt + 6'd1;
                end
            end
            S_MAC: begin
                if (w_last_mac) begin
                    w_cs_nxt    = 1'b1;
                    w_wr_nxt    = 1'b1;
                    w_addr_nxt  = r_dst_base + r_n;
                    w_wdata_nxt = 64'(w_acc_nxt);
                end else if (r_iss_cnt < w_kn) begin
                    w_cs_nxt   = 1'b1;
                    w_addr_nxt = r_src_base + r_n - 14'(r_iss_cnt);
                    w_iss_nxt  = r_iss_cnt + 6'd1;
                end
            end
            S_WRITE: begin
                w_n_nxt = r_n + 14'd1;
                if (!w_last_n) begin
                    w_cs_nxt   = 1'b1;
                    w_addr_nxt = r_src_base + r_n + 14'd1;
                    w_iss_nxt  = 6'd1;
                    w_ret_nxt  = 6'd0;
                    w_acc_clr  = 1'b1;
                end
            end
            S_FINISH: begin
                w_done_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // Output, status and sequencing registers
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_cs        <= 1'b0;
            r_wr        <= 1'b0;
            r_addr      <= 14'd0;
            r_wdata     <= 64'd0;
            r_iss_cnt   <= 6'd0;
            r_ret_cnt   <= 6'd0;
            r_n         <= 14'd0;
            r_rd_pipe   <= '0;
            r_coef_base <= 14'd0;
            r_src_base  <= 14'd0;
            r_dst_base  <= 14'd0;
            r_n_total   <= 14'd0;
            r_taps      <= 6'd0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_error   <= w_err_nxt;
            r_cs      <= w_cs_nxt;
            r_wr      <= w_wr_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_iss_cnt <= w_iss_nxt;
            r_ret_cnt <= w_ret_nxt;
            r_n       <= w_n_nxt;
            r_rd_pipe <= (r_rd_pipe << 1) | RD_LAT'(w_issued);
            if (w_accept) begin
                r_coef_base <= coef_base;
                r_src_base  <= src_base;
                r_dst_base  <= dst_base;
                r_n_total   <= num_samples;
                r_taps      <= num_taps;
            end
        end
    end

    // Accumulator: cleared when an output's first read is issued
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_acc <= '0;
        end else if (w_acc_clr) begin
            r_acc <= '0;
        end else if (r_state == S_MAC) begin
            r_acc <= w_acc_nxt;
        end
    end

    // Coefficient capture as each LOAD read returns
    always_ff @(posedge clk_clk) begin
        if ((r_state == S_LOAD) && w_ret) begin
            r_coef[r_ret_cnt[IDX_W-1:0]] <= w_x;
        end
    end

endmodule

// File: tb/tb_fir_mem_engine.sv
// tb_fir_mem_engine: random and directed jobs against a RAM model; expected
// writes come from a direct convolution over the bench's own h/x arrays.
module tb_fir_mem_engine;

    localparam int RD_LAT  = 1;
    localparam int TIMEOUT = 20000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [13:0] coef_base = '0;
    logic [13:0] src_base = '0;
    logic [13:0] dst_base = '0;
    logic [5:0]  num_taps = '0;
    logic [13:0] num_samples = '0;
    logic        busy;
    logic        done;
    logic        error;
    logic [13:0] s2_address;
    logic        s2_chipselect;
    logic        s2_clken;
    logic        s2_write;
    logic [63:0] s2_writedata;
    logic [7:0]  s2_byteenable;
    logic [63:0] s2_readdata = '0;

    logic [63:0] mem [16384];
    logic [77:0] exp_q [$];
    shortint     h_v [64];
    shortint     x_v [64];

    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int cs_cnt = 0;
    int busy_cycles = 0;

    fir_mem_engine dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .start         (start),
        .coef_base     (coef_base),
        .src_base      (src_base),
        .dst_base      (dst_base),
        .num_taps      (num_taps),
        .num_samples   (num_samples),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .s2_address    (s2_address),
        .s2_chipselect (s2_chipselect),
        .s2_clken      (s2_clken),
        .s2_write      (s2_write),
        .s2_writedata  (s2_writedata),
        .s2_byteenable (s2_byteenable),
        .s2_readdata   (s2_readdata)
    );

    // Clock
    always #5 clk = ~clk;

    // RAM model: one-cycle read latency, writes commit on the strobe cycle
    always @(posedge clk) begin
        if (s2_chipselect) begin
            if (s2_write) mem[s2_address] <= s2_writedata;
            else          s2_readdata <= mem[s2_address];
        end
    end

    // Monitor: counts activity and checks each write against the scoreboard
    always @(negedge clk) begin
        logic [77:0] e;
        if (rst_n) begin
            if (busy) busy_cycles++;
            if (done) done_cnt++;
            if (s2_chipselect) cs_cnt++;
            if (s2_chipselect && s2_write) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL write_unexpected: addr=%h data=%h, required no write", s2_address, s2_writedata);
                end else begin
                    e = exp_q.pop_front();
                    if ({s2_address, s2_writedata} !== e) begin
                        n_fail++;
                        $display("FAIL write: addr=%h data=%h, required addr=%h data=%h",
                                 s2_address, s2_writedata, e[77:64], e[63:0]);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic setup_mem(input logic [13:0] cb, input logic [13:0] sb, input int t, input int n);
        logic [63:0] w;
        for (int k = 0; k < t; k++) begin
            w = {$urandom(), $urandom()};
            w[15:0] = h_v[k];
            mem[14'(int'(cb) + k)] = w;
        end
        for (int i = 0; i < n; i++) begin
            w = {$urandom(), $urandom()};
            w[15:0] = x_v[i];
            mem[14'(int'(sb) + i)] = w;
        end
    endtask

    // Reference: y[n] = sum over k of h[k]*x[n-k], x at negative index is 0
    task automatic push_expected(input logic [13:0] db, input int t, input int n);
        longint y;
        for (int i = 0; i < n; i++) begin
            y = 0;
            for (int k = 0; k < t; k++)
                if (i - k >= 0) y += longint'(h_v[k]) * longint'(x_v[i - k]);
            exp_q.push_back({14'(int'(db) + i), 64'(y)});
        end
    endtask

    task automatic pulse_start(input logic [13:0] cb, input logic [13:0] sb, input logic [13:0] db,
                               input logic [5:0] t, input logic [13:0] n);
        @(posedge clk); #1;
        done_cnt = 0;
        cs_cnt = 0;
        busy_cycles = 0;
        coef_base = cb;
        src_base = sb;
        dst_base = db;
        num_taps = t;
        num_samples = n;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_job(input logic [13:0] cb, input logic [13:0] sb, input logic [13:0] db,
                           input int t, input int n);
        setup_mem(cb, sb, t, n);
        push_expected(db, t, n);
        pulse_start(cb, sb, db, 6'(t), 14'(n));
    endtask

    task automatic wait_and_check(input string tag, input int t, input int n);
        int cyc;
        int bexp;
        int kn;
        cyc = 0;
        while (done !== 1'b1 && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc >= TIMEOUT) begin
            n_fail++;
            $display("FAIL %s_timeout: no done after %0d cycles, required done", tag, cyc);
        end
        repeat (3) @(negedge clk);
        bexp = t + RD_LAT;
        for (int i = 0; i < n; i++) begin
            kn = (i + 1 < t) ? i + 1 : t;
            bexp += kn + RD_LAT + 1;
        end
        bexp += 1;
        chk({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(bexp));
        exp_q.delete();
    endtask

    task automatic no_run_job(input string tag, input logic [5:0] t, input logic [13:0] n, input logic exp_err);
        pulse_start(14'h0, 14'h100, 14'h200, t, n);
        chk({tag, "_done_next"}, 64'(done), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'(exp_err));
        repeat (4) @(negedge clk);
        chk({tag, "_no_access"}, 64'(cs_cnt), 64'd0);
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        chk({tag, "_error_sticky"}, 64'(error), 64'(exp_err));
    endtask

    task automatic rand_fill(input int t, input int n);
        for (int k = 0; k < t; k++) h_v[k] = shortint'($urandom());
        for (int i = 0; i < n; i++) x_v[i] = shortint'($urandom());
    endtask

    // Watchdog
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        int t;
        int n;
        for (int i = 0; i < 16384; i++) mem[i] = 64'd0;

        // Reset values
        repeat (3) @(posedge clk); #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_cs", 64'(s2_chipselect), 64'd0);
        chk("rst_write", 64'(s2_write), 64'd0);
        chk("rst_clken", 64'(s2_clken), 64'd0);
        chk("rst_addr", 64'(s2_address), 64'd0);
        chk("rst_wdata", s2_writedata, 64'd0);
        chk("rst_be", 64'(s2_byteenable), 64'hFF);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic convolution
        h_v[0] = 1; h_v[1] = 2; h_v[2] = 3;
        x_v[0] = 1; x_v[1] = 1; x_v[2] = 1; x_v[3] = 1;
        run_job(14'h0000, 14'h0100, 14'h0200, 3, 4);
        chk("basic_clken", 64'(s2_clken), 64'd1);
        wait_and_check("basic", 3, 4);
        chk("basic_y0", mem[14'h200], 64'd1);
        chk("basic_y1", mem[14'h201], 64'd3);
        chk("basic_y2", mem[14'h202], 64'd6);
        chk("basic_y3", mem[14'h203], 64'd6);

        // Sign extension
        h_v[0] = 1; x_v[0] = -5;
        run_job(14'h0300, 14'h0310, 14'h0320, 1, 1);
        wait_and_check("sign_a", 1, 1);
        chk("sign_a_val", mem[14'h320], 64'hFFFF_FFFF_FFFF_FFFB);
        h_v[0] = -1; x_v[0] = -32768;
        run_job(14'h0300, 14'h0310, 14'h0320, 1, 1);
        wait_and_check("sign_b", 1, 1);
        chk("sign_b_val", mem[14'h320], 64'h0000_0000_0000_8000);

        // Parameter errors, then recovery
        no_run_job("taps0", 6'd0, 14'd4, 1'b1);
        no_run_job("taps33", 6'd33, 14'd4, 1'b1);
        rand_fill(2, 2);
        run_job(14'h0040, 14'h0140, 14'h0240, 2, 2);
        chk("recover_error_cleared", 64'(error), 64'd0);
        wait_and_check("recover", 2, 2);

        // Source address wrap
        h_v[0] = 1; x_v[0] = 2; x_v[1] = 5;
        run_job(14'h0010, 14'h3FFF, 14'h0200, 1, 2);
        wait_and_check("src_wrap", 1, 2);
        chk("src_wrap_y0", mem[14'h200], 64'd2);
        chk("src_wrap_y1", mem[14'h201], 64'd5);

        // Destination address wrap
        h_v[0] = 1; x_v[0] = 7; x_v[1] = 9;
        run_job(14'h0010, 14'h0100, 14'h3FFF, 1, 2);
        wait_and_check("dst_wrap", 1, 2);
        chk("dst_wrap_y0", mem[14'h3FFF], 64'd7);
        chk("dst_wrap_y1", mem[14'h0000], 64'd9);

        // Start while busy is ignored
        rand_fill(3, 5);
        run_job(14'h0400, 14'h0500, 14'h0600, 3, 5);
        repeat (6) @(posedge clk); #1;
        coef_base = 14'h3000; src_base = 14'h3100; dst_base = 14'h3200;
        num_taps = 6'd2; num_samples = 14'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_and_check("busy_start", 3, 5);

        // Empty job
        no_run_job("n0", 6'd3, 14'd0, 1'b0);

        // Reset mid-MAC, then a full run
        rand_fill(4, 8);
        run_job(14'h0700, 14'h0800, 14'h0900, 4, 8);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_cs", 64'(s2_chipselect), 64'd0);
        chk("abort_write", 64'(s2_write), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_clken", 64'(s2_clken), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rand_fill(5, 6);
        run_job(14'h0700, 14'h0800, 14'h0900, 5, 6);
        wait_and_check("after_abort", 5, 6);

        // Full-width tap count
        rand_fill(32, 40);
        run_job(14'h0A00, 14'h1A00, 14'h2A00, 32, 40);
        wait_and_check("taps32", 32, 40);

        // Random jobs
        for (int r = 0; r < 6; r++) begin
            t = $urandom_range(1, 32);
            n = $urandom_range(1, 40);
            rand_fill(t, n);
            run_job(14'($urandom_range(0, 16'h0FC0)), 14'(16'h1000 + $urandom_range(0, 16'h0FC0)),
                    14'(16'h2000 + $urandom_range(0, 16'h0FC0)), t, n);
            wait_and_check("random", t, n);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
